// File: rtl/panda_pkg.sv
// Shared types for the panda pipeline.
//   if_id_t : fetch -> decode payload (instruction word, its address and
//             the sequential successor address).
package panda_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_inc;
  } if_id_t;

endpackage

// File: rtl/panda_if_stage_if.sv
// Instruction-memory request/response bus.
//   req    : fetch request        (master -> slave)
//   addr   : word-aligned address (master -> slave)
//   gnt    : request accepted     (slave -> master)
//   rvalid : rdata valid          (slave -> master)
//   rdata  : instruction word     (slave -> master)
interface panda_if_stage_if;

  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/panda_if_stage.sv
// Instruction fetch stage. Issues one request at a time to instruction
// memory, tracks the outstanding response, and hands fetched words to
// decode through a registered if_id slot backed by a one-entry skid buffer.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   instr                : instruction-memory bus (master side)
//   stall_i              : decode cannot accept, hold if_id_o
//   redirect_i/_pc_i     : restart fetch at a new target
//   if_id_o/_valid_o     : registered payload and valid to decode
module panda_if_stage
  import panda_pkg::*;
#(
  parameter logic [31:0] BootAddr = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  panda_if_stage_if.master         instr,
  input  logic                     stall_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output if_id_t                   if_id_o,
  output logic                     if_id_valid_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_KILL} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  if_id_t      skid_q, skid_d;
  logic        skid_vld_q, skid_vld_d;
  if_id_t      if_id_q, if_id_d;
  logic        if_id_vld_q, if_id_vld_d;

  logic        gnt_ok;
  logic        accept;
  if_id_t      resp;

  // No new request while the skid holds a word: this keeps at most one
  // word in flight beyond if_id, so a response never meets a full skid.
  // Gating with rst_ni keeps the request low while reset is held.
  assign instr.req  = rst_ni && (state_q == S_REQ) && !skid_vld_q;
  assign instr.addr = pc_q;

  assign if_id_o       = if_id_q;
  assign if_id_valid_o = if_id_vld_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    skid_d       = skid_q;
    skid_vld_d   = skid_vld_q;
    if_id_d      = if_id_q;
    if_id_vld_d  = if_id_vld_q;
    accept       = 1'b0;

    gnt_ok      = instr.req && instr.gnt;
    resp.instr  = instr.rdata;
    resp.pc     = fetch_addr_q;
    resp.pc_inc = fetch_addr_q + 32'd4;

    if (redirect_i) begin
      // Redirect overrides stall: flush everything buffered and restart.
      pc_d        = redirect_pc_i & ~32'd3;
      skid_vld_d  = 1'b0;
      if_id_vld_d = 1'b0;
      case (state_q)
        S_REQ:   state_d = gnt_ok ? S_KILL : S_REQ;
        S_WAIT:  state_d = instr.rvalid ? S_REQ : S_KILL;
        S_KILL:  state_d = instr.rvalid ? S_REQ : S_KILL;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (gnt_ok) begin
            fetch_addr_d = pc_q;
            pc_d         = pc_q + 32'd4;
            state_d      = S_WAIT;
          end
        end
        S_WAIT: begin
          if (instr.rvalid) begin
            accept  = 1'b1;
            state_d = S_REQ;
          end
        end
        S_KILL: begin
          // Response to a squashed request: consume and drop it.
          if (instr.rvalid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase

      if (!stall_i) begin
        if (skid_vld_q) begin
          if_id_d     = skid_q;
          if_id_vld_d = 1'b1;
          skid_vld_d  = 1'b0;
        end else if (accept) begin
          if_id_d     = resp;
          if_id_vld_d = 1'b1;
        end else begin
          if_id_vld_d = 1'b0;
        end
      end else if (accept) begin
        // Stalled: only an empty if_id slot may be filled directly.
        if (if_id_vld_q) begin
          skid_d     = resp;
          skid_vld_d = 1'b1;
        end else begin
          if_id_d     = resp;
          if_id_vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_REQ;
      pc_q         <= BootAddr;
      fetch_addr_q <= '0;
      skid_q       <= '0;
      skid_vld_q   <= 1'b0;
      if_id_q      <= '0;
      if_id_vld_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      skid_q       <= skid_d;
      skid_vld_q   <= skid_vld_d;
      if_id_q      <= if_id_d;
      if_id_vld_q  <= if_id_vld_d;
    end
  end

endmodule

// File: tb/tb_panda_if_stage.sv
// Directed bench for panda_if_stage with a zero-wait memory responder
// (grant same cycle, rvalid next cycle) whose response can be held off.
module tb_panda_if_stage;
  import panda_pkg::*;

  logic        clk;
  logic        rst_ni;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  if_id_t      if_id;
  logic        if_id_valid;

  panda_if_stage_if instr_bus ();

  panda_if_stage #(.BootAddr(32'h0000_0000)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .instr         (instr_bus),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .if_id_o       (if_id),
    .if_id_valid_o (if_id_valid)
  );

  int errors = 0;
  int checks = 0;

  // memory responder state
  logic        hold;
  logic        pend;
  logic [31:0] pend_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // A response must never arrive while the skid is occupied.
  always @(posedge clk) begin
    if (instr_bus.rvalid) begin
      checks++;
      if (dut.skid_vld_q !== 1'b0) begin
        errors++;
        $display("FAIL rvalid_with_skid_full: skid_vld=%b required 0", dut.skid_vld_q);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  // One clock: memory answers, edge, then sample point 1 time unit later.
  task automatic tick();
    logic g;
    logic [31:0] a;
    logic sent;
    instr_bus.gnt    = instr_bus.req;
    instr_bus.rvalid = pend && !hold;
    instr_bus.rdata  = (pend && !hold) ? mem_word(pend_addr) : 32'h0;
    g    = instr_bus.req && instr_bus.gnt;
    a    = instr_bus.addr;
    sent = instr_bus.rvalid;
    @(posedge clk);
    #1;
    if (sent) pend = 1'b0;
    if (g) begin
      pend      = 1'b1;
      pend_addr = a;
    end
    instr_bus.gnt    = 1'b0;
    instr_bus.rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) tick();
    checks++; if (instr_bus.req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", instr_bus.req); end
    checks++; if (instr_bus.addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 00000000", instr_bus.addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", if_id_valid); end
    checks++; if (if_id !== '0) begin errors++; $display("FAIL rst_if_id: got %h want 0", if_id); end
    rst_ni = 1'b1;
    #1;
    checks++; if (instr_bus.req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", instr_bus.req); end
  endtask

  task automatic test_fetch_seq();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = 32'(i * 4);
      checks++; if (instr_bus.addr !== a) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, instr_bus.addr, a); end
      tick();
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL seq_gap%0d: valid %b want 0", i, if_id_valid); end
      tick();
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d: got %b want 1", i, if_id_valid); end
      checks++; if (if_id.pc !== a) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, if_id.pc, a); end
      checks++; if (if_id.pc_inc !== a + 32'd4) begin errors++; $display("FAIL seq_pcinc%0d: got %h want %h", i, if_id.pc_inc, a + 32'd4); end
      checks++; if (if_id.instr !== mem_word(a)) begin errors++; $display("FAIL seq_instr%0d: got %h want %h", i, if_id.instr, mem_word(a)); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (if_id_valid !== 1'b1 || if_id.pc !== 32'h8) begin errors++; $display("FAIL stall_hold%0d: valid %b pc %h want 1/00000008", i, if_id_valid, if_id.pc); end
    end
    checks++; if (instr_bus.req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b want 0", instr_bus.req); end
    stall = 1'b0;
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id.pc !== 32'hC) begin errors++; $display("FAIL skid_drain: valid %b pc %h want 1/0000000c", if_id_valid, if_id.pc); end
    checks++; if (if_id.instr !== mem_word(32'hC)) begin errors++; $display("FAIL skid_instr: got %h want %h", if_id.instr, mem_word(32'hC)); end
    checks++; if (instr_bus.req !== 1'b1 || instr_bus.addr !== 32'h10) begin errors++; $display("FAIL after_drain_req: req %b addr %h want 1/00000010", instr_bus.req, instr_bus.addr); end
    tick();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL no_dup: valid %b want 0", if_id_valid); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id.pc !== 32'h10) begin errors++; $display("FAIL post_stall: valid %b pc %h want 1/00000010", if_id_valid, if_id.pc); end
  endtask

  task automatic test_redirect_wait();
    hold = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    checks++; if (instr_bus.addr !== 32'h100) begin errors++; $display("FAIL redir_addr: got %h want 00000100", instr_bus.addr); end
    checks++; if (instr_bus.req !== 1'b0) begin errors++; $display("FAIL redir_kill_req: got %b want 0", instr_bus.req); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b want 0", if_id_valid); end
    hold = 1'b0;
    tick();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL kill_drop: valid %b want 0", if_id_valid); end
    checks++; if (instr_bus.req !== 1'b1) begin errors++; $display("FAIL kill_to_req: got %b want 1", instr_bus.req); end
    tick();
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id.pc !== 32'h100 || if_id.pc_inc !== 32'h104) begin errors++; $display("FAIL redir_fetch: valid %b pc %h inc %h want 1/00000100/00000104", if_id_valid, if_id.pc, if_id.pc_inc); end
    checks++; if (if_id.instr !== mem_word(32'h100)) begin errors++; $display("FAIL redir_instr: got %h want %h", if_id.instr, mem_word(32'h100)); end
  endtask

  task automatic test_redirect_stall_skid();
    stall = 1'b1;
    tick();
    tick();
    checks++; if (instr_bus.req !== 1'b0 || if_id.pc !== 32'h100) begin errors++; $display("FAIL skid_full: req %b pc %h want 0/00000100", instr_bus.req, if_id.pc); end
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rs_valid: got %b want 0", if_id_valid); end
    checks++; if (instr_bus.req !== 1'b1 || instr_bus.addr !== 32'h200) begin errors++; $display("FAIL rs_restart: req %b addr %h want 1/00000200", instr_bus.req, instr_bus.addr); end
    stall = 1'b0;
    tick();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rs_skid_cleared: valid %b want 0", if_id_valid); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id.pc !== 32'h200) begin errors++; $display("FAIL rs_fetch: valid %b pc %h want 1/00000200", if_id_valid, if_id.pc); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    checks++; if (instr_bus.req !== 1'b0) begin errors++; $display("FAIL wrap_kill: req %b want 0", instr_bus.req); end
    tick();
    checks++; if (if_id_valid !== 1'b0 || instr_bus.addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: valid %b addr %h want 0/fffffffc", if_id_valid, instr_bus.addr); end
    tick();
    checks++; if (instr_bus.addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h want 00000000", instr_bus.addr); end
    tick();
    checks++; if (if_id.pc !== 32'hFFFF_FFFC || if_id.pc_inc !== 32'h0) begin errors++; $display("FAIL wrap_pcinc: pc %h inc %h want fffffffc/00000000", if_id.pc, if_id.pc_inc); end
    checks++; if (if_id.instr !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_instr: got %h want %h", if_id.instr, mem_word(32'hFFFF_FFFC)); end
  endtask

  task automatic test_reset_mid();
    hold = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect = 1'b0;
    hold = 1'b0;
    tick();
    hold = 1'b1;
    tick();
    checks++; if (instr_bus.addr !== 32'h304 || instr_bus.req !== 1'b0) begin errors++; $display("FAIL mid_wait: addr %h req %b want 00000304/0", instr_bus.addr, instr_bus.req); end
    rst_ni = 1'b0;
    #1;
    checks++; if (instr_bus.addr !== 32'h0 || instr_bus.req !== 1'b0) begin errors++; $display("FAIL mid_rst: addr %h req %b want 00000000/0", instr_bus.addr, instr_bus.req); end
    checks++; if (if_id !== '0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_ifid: %h valid %b want 0/0", if_id, if_id_valid); end
    tick();
    rst_ni = 1'b1;
    #1;
    hold = 1'b0;
    tick();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL late_rvalid: valid %b want 0", if_id_valid); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id.pc !== 32'h0) begin errors++; $display("FAIL boot_refetch: valid %b pc %h want 1/00000000", if_id_valid, if_id.pc); end
    checks++; if (if_id.instr !== mem_word(32'h0)) begin errors++; $display("FAIL boot_instr: got %h want %h", if_id.instr, mem_word(32'h0)); end
  endtask

  initial begin
    rst_ni = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    hold = 1'b0;
    pend = 1'b0;
    pend_addr = 32'h0;
    instr_bus.gnt = 1'b0;
    instr_bus.rvalid = 1'b0;
    instr_bus.rdata = 32'h0;
    test_reset();
    test_fetch_seq();
    test_stall();
    test_redirect_wait();
    test_redirect_stall_skid();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
